// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse initialisation sequencer: frames each command of a fixed init
// table, hands it to the host-to-device transmitter, checks the device reply
// and retries a step on transmit error, NAK, wrong byte or reply timeout.
module ps2_mouse_init_seq #(
    parameter logic [7:0]  SAMPLE_RATE = 8'd200,
    parameter logic [7:0]  RESOLUTION  = 8'd3,
    parameter int unsigned ACK_TIMEOUT = 1_000_000,
    parameter int unsigned BAT_TIMEOUT = 50_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        qzt_clk,
    input  logic        reset,
    input  logic        start,
    output logic [10:0] tx_data,
    output logic        tx_send,
    input  logic        tx_ok,
    input  logic        tx_err,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [2:0]  step,
    output logic [1:0]  retry_cnt
);

    localparam int unsigned TIMER_W = 27;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned RETRY_W = 2;
    localparam int unsigned FRAME_W = 11;

    localparam logic [TIMER_W-1:0] ACK_LAST   = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BAT_LAST   = TIMER_W'(BAT_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(5);
    localparam logic [FRAME_W-1:0] FRAME_IDLE = 11'h7FF;

    localparam logic [7:0] BYTE_ACK = 8'hFA;
    localparam logic [7:0] BYTE_BAT = 8'hAA;
    localparam logic [7:0] BYTE_ID  = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_WAIT_ID,
        S_RETRY,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_e;

    state_e               state_q,     state_d;
    logic [FRAME_W-1:0]   tx_data_q,   tx_data_d;
    logic                 tx_send_q,   tx_send_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic                 fail_q,      fail_d;
    logic [STEP_W-1:0]    step_q,      step_d;
    logic [RETRY_W-1:0]   retry_q,     retry_d;
    logic [TIMER_W-1:0]   timer_q,     timer_d;

    // Init command table: reset, set sample rate, set resolution, enable reporting
    function automatic logic [7:0] table_byte(input logic [STEP_W-1:0] idx);
        case (idx)
            3'd0:    table_byte = 8'hFF;
            3'd1:    table_byte = 8'hF3;
            3'd2:    table_byte = SAMPLE_RATE;
            3'd3:    table_byte = 8'hE8;
            3'd4:    table_byte = RESOLUTION;
            default: table_byte = 8'hF4;
        endcase
    endfunction

    // Frame: start 0, data LSB first, odd parity, stop 1 (bit 0 goes out first)
    function automatic logic [FRAME_W-1:0] cmd_frame(input logic [7:0] b);
        cmd_frame = {1'b1, ~^b, b, 1'b0};
    endfunction

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_send_d = tx_send_q;
        busy_d    = busy_q;
        done_d    = done_q;
        fail_d    = fail_q;
        step_d    = step_q;
        retry_d   = retry_q;
        timer_d   = timer_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                    retry_d = '0;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                tx_data_d = cmd_frame(table_byte(step_q));
                tx_send_d = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_ok) begin
                    tx_send_d = 1'b0;
                    timer_d   = '0;
                    state_d   = tx_err ? S_RETRY : S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                timer_d = timer_q + TIMER_W'(1);
                if (rx_valid) begin
                    timer_d = '0;
                    if (rx_byte == BYTE_ACK) begin
                        state_d = (step_q == '0) ? S_WAIT_BAT : S_NEXT;
                    end else begin
                        state_d = S_RETRY;
                    end
                end else if (timer_q == ACK_LAST) begin
                    state_d = S_RETRY;
                end
            end
            S_WAIT_BAT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (rx_valid) begin
                    timer_d = '0;
                    state_d = (rx_byte == BYTE_BAT) ? S_WAIT_ID : S_RETRY;
                end else if (timer_q == BAT_LAST) begin
                    state_d = S_RETRY;
                end
            end
            S_WAIT_ID: begin
                timer_d = timer_q + TIMER_W'(1);
                if (rx_valid) begin
                    timer_d = '0;
                    state_d = (rx_byte == BYTE_ID) ? S_NEXT : S_RETRY;
                end else if (timer_q == BAT_LAST) begin
                    state_d = S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry_q == RETRY_MAX) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_NEXT: begin
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    retry_d = '0;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_data_q <= FRAME_IDLE;
            tx_send_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            step_q    <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            step_q    <= step_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_send   = tx_send_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign step      = step_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Directed bench for ps2_mouse_init_seq: plays transmitter and mouse by hand.
module tb_ps2_mouse_init_seq;

    logic        qzt_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] tx_data;
    logic        tx_send;
    logic        tx_ok;
    logic        tx_err;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        fail;
    logic [2:0]  step;
    logic [1:0]  retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed frames {stop, odd parity, byte, start}
    localparam logic [10:0] F_FF = 11'h7FE;
    localparam logic [10:0] F_F3 = 11'h7E6;
    localparam logic [10:0] F_C8 = 11'h590;
    localparam logic [10:0] F_E8 = 11'h7D0;
    localparam logic [10:0] F_03 = 11'h606;
    localparam logic [10:0] F_F4 = 11'h5E8;

    ps2_mouse_init_seq #(
        .SAMPLE_RATE (8'd200),
        .RESOLUTION  (8'd3),
        .ACK_TIMEOUT (100),
        .BAT_TIMEOUT (200),
        .MAX_RETRY   (3)
    ) dut (
        .qzt_clk   (qzt_clk),
        .reset     (reset),
        .start     (start),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_ok     (tx_ok),
        .tx_err    (tx_err),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .step      (step),
        .retry_cnt (retry_cnt)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic tick;
        @(posedge qzt_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_send(input string tag, input int budget);
        int n = 0;
        while (tx_send !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, " send"}, 32'(tx_send), 32'd1);
    endtask

    // Accept one frame: check its contents, then finish it with tx_ok/tx_err
    task automatic frame(input string tag, input logic [10:0] exp, input logic err,
                         input logic disturb);
        wait_send(tag, 1000);
        check({tag, " data"}, 32'(tx_data), 32'(exp));
        tick();
        tick();
        if (disturb) begin
            start    = 1'b1;
            rx_byte  = 8'h08;
            rx_valid = 1'b1;
            tick();
            start    = 1'b0;
            rx_valid = 1'b0;
            check({tag, " hold"}, 32'(tx_send), 32'd1);
            check({tag, " busy"}, 32'(busy), 32'd1);
        end
        tx_ok  = 1'b1;
        tx_err = err;
        tick();
        tx_ok  = 1'b0;
        tx_err = 1'b0;
        check({tag, " drop"}, 32'(tx_send), 32'd0);
    endtask

    task automatic reply(input logic [7:0] b);
        tick();
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic step_ok(input string tag, input logic [10:0] exp);
        frame(tag, exp, 1'b0, 1'b0);
        reply(8'hFA);
    endtask

    task automatic step0_ok(input string tag);
        frame(tag, F_FF, 1'b0, 1'b0);
        reply(8'hFA);
        reply(8'hAA);
        reply(8'h00);
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && fail !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, " ended"}, 32'(done | fail), 32'd1);
    endtask

    task automatic check_done(input string tag);
        wait_end(tag, 50);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " fail"}, 32'(fail), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " tx_data"},   32'(tx_data),   32'h7FF);
        check({tag, " tx_send"},   32'(tx_send),   32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " done"},      32'(done),      32'd0);
        check({tag, " fail"},      32'(fail),      32'd0);
        check({tag, " step"},      32'(step),      32'd0);
        check({tag, " retry_cnt"}, 32'(retry_cnt), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tx_ok    = 1'b0;
        tx_err   = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_vals("rst");

        // T1: clean run, also checks start-to-send latency
        pulse_start();
        check("t1 busy", 32'(busy), 32'd1);
        check("t1 early", 32'(tx_send), 32'd0);
        tick();
        check("t1 send2", 32'(tx_send), 32'd1);
        step0_ok("t1 ff");
        step_ok("t1 f3", F_F3);
        step_ok("t1 c8", F_C8);
        step_ok("t1 e8", F_E8);
        step_ok("t1 03", F_03);
        step_ok("t1 f4", F_F4);
        check_done("t1");

        // T2: NAK on step 1, retry then counter clears on step 2
        pulse_start();
        check("t2 done clr", 32'(done), 32'd0);
        step0_ok("t2 ff");
        frame("t2 f3", F_F3, 1'b0, 1'b0);
        reply(8'hFE);
        wait_send("t2 resend", 50);
        check("t2 retry", 32'(retry_cnt), 32'd1);
        check("t2 step1", 32'(step), 32'd1);
        step_ok("t2 f3b", F_F3);
        wait_send("t2 c8", 50);
        check("t2 retry0", 32'(retry_cnt), 32'd0);
        check("t2 step2", 32'(step), 32'd2);
        step_ok("t2 c8", F_C8);
        step_ok("t2 e8", F_E8);
        step_ok("t2 03", F_03);
        step_ok("t2 f4", F_F4);
        check_done("t2");

        // T4: transmitter error on the last step
        pulse_start();
        step0_ok("t4 ff");
        step_ok("t4 f3", F_F3);
        step_ok("t4 c8", F_C8);
        step_ok("t4 e8", F_E8);
        step_ok("t4 03", F_03);
        frame("t4 f4", F_F4, 1'b1, 1'b0);
        wait_send("t4 resend", 50);
        check("t4 retry", 32'(retry_cnt), 32'd1);
        check("t4 step5", 32'(step), 32'd5);
        step_ok("t4 f4b", F_F4);
        check_done("t4");

        // T6: start while busy and stray byte during WAIT_TX are ignored
        pulse_start();
        frame("t6 ff", F_FF, 1'b0, 1'b1);
        check("t6 step", 32'(step), 32'd0);
        reply(8'hFA);
        reply(8'hAA);
        reply(8'h00);
        step_ok("t6 f3", F_F3);
        step_ok("t6 c8", F_C8);
        step_ok("t6 e8", F_E8);
        step_ok("t6 03", F_03);
        step_ok("t6 f4", F_F4);
        check_done("t6");

        // T3: no reply to reset command exhausts retries
        pulse_start();
        frame("t3 a0", F_FF, 1'b0, 1'b0);
        frame("t3 a1", F_FF, 1'b0, 1'b0);
        frame("t3 a2", F_FF, 1'b0, 1'b0);
        frame("t3 a3", F_FF, 1'b0, 1'b0);
        wait_end("t3", 300);
        check("t3 fail", 32'(fail), 32'd1);
        check("t3 done", 32'(done), 32'd0);
        check("t3 busy", 32'(busy), 32'd0);
        check("t3 step", 32'(step), 32'd0);
        check("t3 retry", 32'(retry_cnt), 32'd3);
        check("t3 quiet", 32'(tx_send), 32'd0);

        // T5: reset during WAIT_TX of step 3, then clean restart
        pulse_start();
        check("t5 fail clr", 32'(fail), 32'd0);
        step0_ok("t5 ff");
        step_ok("t5 f3", F_F3);
        step_ok("t5 c8", F_C8);
        wait_send("t5 e8", 50);
        check("t5 e8 data", 32'(tx_data), 32'(F_E8));
        tick();
        check("t5 step3", 32'(step), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("t5 rst");
        pulse_start();
        step0_ok("t5 ff2");
        step_ok("t5 f3b", F_F3);
        step_ok("t5 c8b", F_C8);
        step_ok("t5 e8b", F_E8);
        step_ok("t5 03", F_03);
        step_ok("t5 f4", F_F4);
        check_done("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
